rc4_memory_bank: RTL and testbench

Memory subsystem of the RC4 decryption circuit. Groups three synchronous single-port memories behind one clock domain: the 256-byte state array S (read/write), the 32-byte encrypted-message ROM, and the 32-byte decrypted-message RAM. Sits between the key-scheduling/decrypt FSMs (which drive addresses, data and write enables) and their data inputs.

---
 rtl/rc4_memory_bank.sv | 110 +++++++++++
 tb/tb_rc4_memory_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_memory_bank.sv
// -----------------------------------------------------------------------------
// rc4_memory_bank
//
// Memory subsystem of the RC4 decryption circuit. It holds three independent
// single-port synchronous memories that share one clock:
//   - S array       : S_DEPTH x DATA_W, read/write (RC4 state permutation)
//   - encrypted ROM : MSG_DEPTH x DATA_W, read-only, loaded at elaboration
//   - decrypted RAM : MSG_DEPTH x DATA_W, read/write
//
// Every port registers its address on the rising edge. Read data is looked up
// from the registered address, so q is valid one cycle after the address is
// presented. A write updates the array at the same edge, which makes a read of
// the location being written return the new data.
//
// Ports:
//   clk          in   clock, rising-edge active
//   rst          in   asynchronous active-low reset (forces all q to 0)
//   s_address    in   S read/write address
//   s_data       in   S write data
//   s_wren       in   S write enable
//   s_q          out  S read data
//   enc_address  in   encrypted ROM address (low bits used, aliases)
//   enc_q        out  encrypted ROM read data
//   dec_address  in   decrypted RAM address (low bits used, aliases)
//   dec_data     in   decrypted RAM write data
//   dec_wren     in   decrypted RAM write enable
//   dec_q        out  decrypted RAM read data
//
// ENC_INIT_IMAGE supplies the ROM contents; words it leaves unset read 0.
// -----------------------------------------------------------------------------
module rc4_memory_bank #(
  parameter int                          S_DEPTH        = 256,
  parameter int                          MSG_DEPTH      = 32,
  parameter string                       ENC_INIT_FILE  = "enc_message.hex",
  parameter int                          DATA_W         = 8,
  parameter logic [MSG_DEPTH*DATA_W-1:0] ENC_INIT_IMAGE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_address,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_wren,
  output logic [DATA_W-1:0] s_q,
  input  logic [7:0]        enc_address,
  output logic [DATA_W-1:0] enc_q,
  input  logic [7:0]        dec_address,
  input  logic [DATA_W-1:0] dec_data,
  input  logic              dec_wren,
  output logic [DATA_W-1:0] dec_q
);

  localparam int S_AW   = $clog2(S_DEPTH);
  localparam int MSG_AW = $clog2(MSG_DEPTH);

  typedef logic [MSG_DEPTH*DATA_W-1:0] enc_image_t;

  // Storage. S and decrypted RAM power up cleared; ROM comes from the image.
  logic [DATA_W-1:0] s_mem   [S_DEPTH]   = '{default: '0};
  logic [DATA_W-1:0] dec_mem [MSG_DEPTH] = '{default: '0};
  enc_image_t        enc_rom;

  assign enc_rom = ENC_INIT_IMAGE;

  // Registered addresses plus a flag that keeps q at zero from reset until
  // the first edge after release has captured a real address.
  logic [S_AW-1:0]   s_addr_q;
  logic [MSG_AW-1:0] enc_addr_q;
  logic [MSG_AW-1:0] dec_addr_q;
  logic              rd_vld_q;

  // Message memories only decode the low address bits; upper bits alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{enc_address[7:MSG_AW], dec_address[7:MSG_AW]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_addr_q   <= '0;
      enc_addr_q <= '0;
      dec_addr_q <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      s_addr_q   <= s_address[S_AW-1:0];
      enc_addr_q <= enc_address[MSG_AW-1:0];
      dec_addr_q <= dec_address[MSG_AW-1:0];
      rd_vld_q   <= 1'b1;
    end
  end

  // NOTE: the arrays sit in a clock-only process with no reset branch, so
  // they map onto block RAM and keep their contents across reset. Writes are
  // blocked while rst is low by qualifying the enable. An X enable takes the
  // false branch in simulation, i.e. no write.
  always_ff @(posedge clk) begin
    if (rst && s_wren) begin
      s_mem[s_address[S_AW-1:0]] <= s_data;
    end
    if (rst && dec_wren) begin
      dec_mem[dec_address[MSG_AW-1:0]] <= dec_data;
    end
  end

  // Lookup from the registered address: one cycle latency, and a write at
  // the same edge is already visible (write-through).
  assign s_q   = rd_vld_q ? s_mem[s_addr_q]                       : '0;
  assign enc_q = rd_vld_q ? enc_rom[enc_addr_q*DATA_W +: DATA_W] : '0;
  assign dec_q = rd_vld_q ? dec_mem[dec_addr_q]                   : '0;

endmodule

// File: tb/tb_rc4_memory_bank.sv
// -----------------------------------------------------------------------------
// tb_rc4_memory_bank
//
// Directed self-checking bench for rc4_memory_bank. Inputs change 1 ns after
// a rising edge; outputs are checked at that same point, i.e. after the edge
// has taken effect and well before the next one.
// -----------------------------------------------------------------------------
module tb_rc4_memory_bank;

  function automatic logic [7:0] img_byte(int i);
    logic [7:0] k;
    k = 8'(i * 13);
    return 8'h5A ^ k;
  endfunction

  function automatic logic [255:0] mk_img();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = img_byte(i);
    return r;
  endfunction

  localparam logic [255:0] ENC_IMG = mk_img();

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_address, s_data, s_q;
  logic       s_wren;
  logic [7:0] enc_address, enc_q;
  logic [7:0] dec_address, dec_data, dec_q;
  logic       dec_wren;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rc4_memory_bank #(
    .S_DEPTH       (256),
    .MSG_DEPTH     (32),
    .ENC_INIT_FILE (""),
    .DATA_W        (8),
    .ENC_INIT_IMAGE(ENC_IMG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_address  (s_address),
    .s_data     (s_data),
    .s_wren     (s_wren),
    .s_q        (s_q),
    .enc_address(enc_address),
    .enc_q      (enc_q),
    .dec_address(dec_address),
    .dec_data   (dec_data),
    .dec_wren   (dec_wren),
    .dec_q      (dec_q)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    s_address   = 8'h10;
    s_data      = 8'h00;
    s_wren      = 1'b0;
    enc_address = 8'h03;
    dec_address = 8'h07;
    dec_data    = 8'h00;
    dec_wren    = 1'b0;
    #1 rst = 1'b0;

    // Reset held for 4 cycles: every q stays 0.
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rst_s_%0d", c),   s_q,   8'h00);
      check($sformatf("rst_enc_%0d", c), enc_q, 8'h00);
      check($sformatf("rst_dec_%0d", c), dec_q, 8'h00);
    end

    // Release: first edge registers the address.
    rst = 1'b1;
    step();
    check("rel_s",   s_q,   8'h00);
    check("rel_enc", enc_q, img_byte(3));
    check("rel_dec", dec_q, 8'h00);

    // Fill S[i] = i; write-through shows the new byte after each edge.
    s_wren = 1'b1;
    for (int i = 0; i < 256; i++) begin
      s_address = 8'(i);
      s_data    = 8'(i);
      step();
      check($sformatf("s_wr_%0d", i), s_q, 8'(i));
    end
    s_wren = 1'b0;

    // Sequential read: q holds the previous word until the edge.
    for (int i = 0; i < 256; i++) begin
      s_address = 8'(i);
      #1 check($sformatf("s_hold_%0d", i), s_q, 8'(i - 1));
      step();
      check($sformatf("s_rd_%0d", i), s_q, 8'(i));
    end

    // Read-during-write then a plain read of the same location.
    s_address = 8'h42;
    s_data    = 8'hA5;
    s_wren    = 1'b1;
    step();
    check("rdw_wr", s_q, 8'hA5);
    s_wren = 1'b0;
    s_data = 8'h00;
    step();
    check("rdw_rd", s_q, 8'hA5);

    // Back-to-back writes to one address: last value wins.
    s_address = 8'h10;
    s_wren    = 1'b1;
    s_data    = 8'h01;
    step();
    s_data = 8'h02;
    step();
    s_wren = 1'b0;
    s_address = 8'h11;
    step();
    s_address = 8'h10;
    step();
    check("s_last_wins", s_q, 8'h02);

    // Encrypted ROM sweep and aliasing.
    for (int i = 0; i < 32; i++) begin
      enc_address = 8'(i);
      step();
      check($sformatf("enc_%0d", i), enc_q, img_byte(i));
    end
    enc_address = 8'h20;
    step();
    check("enc_alias_20", enc_q, img_byte(0));
    enc_address = 8'h3F;
    step();
    check("enc_alias_3f", enc_q, img_byte(31));
    enc_address = 8'h25;
    step();
    check("enc_alias_25", enc_q, img_byte(5));

    // Decrypted RAM fill, sweep, aliased write.
    dec_wren = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dec_address = 8'(i);
      dec_data    = 8'(8'h61 + i);
      step();
      check($sformatf("dec_wr_%0d", i), dec_q, 8'(8'h61 + i));
    end
    dec_wren = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dec_address = 8'(31 - i);
      step();
      check($sformatf("dec_rd_%0d", 31 - i), dec_q, 8'(8'h61 + 31 - i));
    end
    dec_address = 8'h23;
    dec_data    = 8'hEE;
    dec_wren    = 1'b1;
    step();
    dec_wren    = 1'b0;
    dec_address = 8'h04;
    step();
    check("dec_nbr_04", dec_q, 8'h65);
    dec_address = 8'h03;
    step();
    check("dec_alias_03", dec_q, 8'hEE);

    // Mid-sweep reset: asynchronous clear, write blocked, contents survive.
    for (int i = 8'h7C; i < 8'h80; i++) begin
      s_address = 8'(i);
      step();
      check($sformatf("pre_rst_s_%0d", i), s_q, 8'(i));
    end
    #2 rst = 1'b0;
    #1;
    check("async_s",   s_q,   8'h00);
    check("async_enc", enc_q, 8'h00);
    check("async_dec", dec_q, 8'h00);
    s_address   = 8'h80;
    s_data      = 8'h11;
    s_wren      = 1'b1;
    dec_address = 8'h05;
    dec_data    = 8'h22;
    dec_wren    = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("mid_rst_s_%0d", c),   s_q,   8'h00);
      check($sformatf("mid_rst_dec_%0d", c), dec_q, 8'h00);
    end
    s_wren   = 1'b0;
    dec_wren = 1'b0;
    rst      = 1'b1;
    step();
    check("post_rst_s80",  s_q,   8'h80);
    check("post_rst_dec5", dec_q, 8'h66);
    check("post_rst_enc",  enc_q, img_byte(5));
    s_address = 8'h42;
    step();
    check("post_rst_s42", s_q, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
